mips16_mem_arbiter: RTL
=======================

Name: mips16_mem_arbiter

Overview:
Single-port memory arbiter for the 16-bit MIPS core. It shares one synchronous single-port SRAM (13-bit word address, 16-bit data) between two requesters: the instruction-fetch stage (IF) and the load/store stage (DM). Data accesses have fixed priority, and a starvation guard forces a fetch grant after a bounded number of losses. It sits between the core's IF/MEM stages and the unified memory; the core stalls on the absence of grant or rvalid.

Parameters:
- ADDR_W, 13, word address width (matches 13-bit PC).
- DATA_W, 16, data width.
- MEM_LAT, 1, SRAM read latency in cycles (1..4).
- STARVE_MAX, 3, consecutive IF losses before IF is forced to win (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- dm_req  in  1  data request; held with addr/we/wdata until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data request accepted.
- dm_rvalid  out  1  load data valid.
- dm_rdata  out  DATA_W  load data.
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid MEM_LAT cycles after mem_en with mem_we=0.

Behaviour:
- States: IDLE, RD_WAIT. State, owner (IF/DM), lat_cnt and starve_cnt are registered. All other outputs are combinational from state and inputs.
- rst low: state=IDLE, owner=IF, lat_cnt=0, starve_cnt=0. Every output is forced to 0 while rst is low. An in-flight read is dropped; no rvalid is issued for it after reset releases.
- IDLE arbitration (one grant max per cycle):
  - Only one req: that requester wins.
  - Both requesting: DM wins, unless starve_cnt==STARVE_MAX, in which case IF wins.
- IDLE with a winner:
  - Assert the winner's gnt and mem_en.
  - mem_addr, mem_we, mem_wdata come from the winner. IF always reads; mem_wdata=0 for IF.
- Starvation counter:
  - starve_cnt increments when both request and DM wins.
  - starve_cnt clears whenever IF is granted.
  - starve_cnt saturates at STARVE_MAX.
- Store grant: the write completes in the grant cycle. State stays IDLE, so a new grant is possible next cycle. No rvalid is produced.
- Load/fetch grant: state goes to RD_WAIT, owner is latched, and lat_cnt is loaded with MEM_LAT-1.
- RD_WAIT:
  - No grants and mem_en=0.
  - While lat_cnt>0, decrement it.
  - When lat_cnt==0, assert the owner's rvalid for exactly 1 cycle, with rdata = mem_rdata (pass-through), then go to IDLE.
- Read throughput: one read per MEM_LAT+1 cycles. With MEM_LAT=1: grant at cycle t, rvalid at t+1, next grant possible at t+2.
- The non-owner's rdata outputs are 0 whenever its rvalid is 0.
- A req dropped before grant has no effect and no state change. A req held high after gnt is treated as a new request.
- Requests arriving during RD_WAIT wait. Arbitration happens in the first IDLE cycle.
- No address range check. Address wraps naturally at 2^ADDR_W.

Decomposition:
- Shared package mips16_pkg:
  - ADDR_W/DATA_W constants.
  - State enum {IDLE, RD_WAIT}.
  - Owner encoding {OWN_IF=0, OWN_DM=1}.
- One natural sub-module: mips16_starve_ctr, the saturating counter with inc/clr/at_max outputs, parameterised by STARVE_MAX.
- Arbitration and datapath muxing stay inline.

Test Plan:
- IF-only read, MEM_LAT=1, SRAM[0x0005]=0x1234:
  - if_req with addr 0x0005 at t gives if_gnt=1 and mem_en=1 at t.
  - if_rvalid=1 with if_rdata=0x1234 at t+1; if_rvalid=0 at t+2.
- DM store then load:
  - Store 0x00AB to addr 3: dm_gnt with mem_we=1 at t, no dm_rvalid, state stays IDLE.
  - Load addr 3 at t+1 gives dm_rvalid with dm_rdata=0x00AB at t+2.
- Simultaneous requests, STARVE_MAX=3, both held continuously, DM issuing back-to-back loads:
  - Grants are DM, DM, DM, IF, DM...
  - starve_cnt reads 1, 2, 3, then 0 after the IF grant.
- Reset mid-read:
  - MEM_LAT=2, IF granted, rst pulled low during RD_WAIT.
  - All outputs go to 0 immediately; after release no if_rvalid appears and the first grant follows normal arbitration.
- MEM_LAT=4 DM load:
  - dm_gnt at t, dm_rvalid exactly at t+4.
  - IF request raised at t+1 is not granted before t+5.
- Request withdrawal: dm_req pulsed for one cycle during RD_WAIT and dropped before IDLE gives no dm_gnt, no mem_en, and starve_cnt unchanged.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared types for the 16-bit MIPS memory subsystem.
// Word address/data widths, arbiter state and owner encodings.
package mips16_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mips16_starve_ctr.sv
// Saturating count of consecutive fetch losses.
// at_max tells the arbiter to hand the next contested slot to fetch.
module mips16_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign at_max = (cnt_q == MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips16_mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store.
// Data side has priority; a starvation guard forces a fetch grant.
module mips16_mem_arbiter #(
    parameter int ADDR_W     = mips16_pkg::ADDR_W,
    parameter int DATA_W     = mips16_pkg::DATA_W,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LW = 2;
    localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);

    mips16_pkg::state_e state_q;
    mips16_pkg::state_e state_d;
    mips16_pkg::owner_e owner_q;
    mips16_pkg::owner_e owner_d;
    logic [LW-1:0]      lat_q;
    logic [LW-1:0]      lat_d;
    logic               starve_inc;
    logic               starve_clr;
    logic               starve_max;
    logic               if_win;
    logic               dm_win;

    mips16_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .at_max(starve_max)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lat_d      = lat_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        if_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        dm_gnt     = 1'b0;
        dm_rvalid  = 1'b0;
        dm_rdata   = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if_win     = if_req && (!dm_req || starve_max);
        dm_win     = dm_req && !if_win;

        unique case (state_q)
            mips16_pkg::IDLE: begin
                unique case (1'b1)
                    if_win: begin
                        if_gnt     = 1'b1;
                        mem_en     = 1'b1;
                        mem_addr   = if_addr;
                        starve_clr = 1'b1;
                        state_d    = mips16_pkg::RD_WAIT;
                        owner_d    = mips16_pkg::OWN_IF;
                        lat_d      = LAT_LOAD;
                    end
                    dm_win: begin
                        dm_gnt     = 1'b1;
                        mem_en     = 1'b1;
                        mem_we     = dm_we;
                        mem_addr   = dm_addr;
                        mem_wdata  = dm_wdata;
                        starve_inc = if_req;
                        // Stores retire in the grant cycle.
                        if (!dm_we) begin
                            state_d = mips16_pkg::RD_WAIT;
                            owner_d = mips16_pkg::OWN_DM;
                            lat_d   = LAT_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
            mips16_pkg::RD_WAIT: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else begin
                    state_d = mips16_pkg::IDLE;
                    if (owner_q == mips16_pkg::OWN_DM) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
            end
            default: ;
        endcase

        // Outputs stay quiet for the whole reset window.
        if (!rst) begin
            if_gnt    = 1'b0;
            if_rvalid = 1'b0;
            if_rdata  = '0;
            dm_gnt    = 1'b0;
            dm_rvalid = 1'b0;
            dm_rdata  = '0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= mips16_pkg::IDLE;
            owner_q <= mips16_pkg::OWN_IF;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
        end
    end

endmodule
